// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg: gesture states, counter sizing, event bit slots.
// Shared by the decoder top; no ports.
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED   = 3'd1,
    S_WAIT_GAP  = 3'd2,
    S_SECOND    = 3'd3,
    S_LONG_HELD = 3'd4
  } state_e;

  localparam int EV_SHORT  = 0;
  localparam int EV_LONG   = 1;
  localparam int EV_DOUBLE = 2;
  localparam int EV_W      = 3;

  // Counter width: enough for the largest timing parameter plus one bit.
  function automatic int cnt_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// button_event_decoder_edge_detect: registers the previous button level.
// Ports: i_clk, i_rst_n (async low), i_d level; o_rise / o_fall combinational.
module button_event_decoder_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  // prev clears to 0 so a level already high at reset release is a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;
  assign o_fall = ~i_d & r_prev;

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies a debounced button into short/long/double.
// Ports: i_clk, i_rst_n (async low), i_btn level in; o_short, o_long,
// o_double, o_repeat 1-cycle pulses; o_held level while long-held.
// Macro BTN_AUTOREPEAT_EN enables o_repeat; otherwise it is tied 0.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_PRESS_CLKS = 24000000,
  parameter int DOUBLE_GAP_CLKS = 6000000,
  parameter int REPEAT_CLKS     = 3000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_held,
  output logic o_repeat
);

  localparam int CW = cnt_w(
    LONG_PRESS_CLKS, DOUBLE_GAP_CLKS, REPEAT_CLKS);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LONG_LAST =
    CW'(LONG_PRESS_CLKS - 1);
  localparam logic [CW-1:0] GAP_LAST  =
    CW'(DOUBLE_GAP_CLKS - 1);

  state_e            r_state;
  state_e            w_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [CW-1:0]     w_inc;
  logic [EV_W-1:0]   r_evt;
  logic [EV_W-1:0]   w_evt;
  logic              r_held;
  logic              w_rise;
  logic              w_fall;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CLKS - 1);
  logic r_rep;
  logic w_rep;
`endif

  button_event_decoder_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // The sample that enters PRESSED / WAIT_GAP is itself the first
  // high / low sample of that phase, so the count restarts at 1.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_evt     = '0;
`ifdef BTN_AUTOREPEAT_EN
    w_rep     = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_next    = S_PRESSED;
          w_cnt_nxt = CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (w_fall) begin
          w_next    = S_WAIT_GAP;
          w_cnt_nxt = CNT_ONE;
        end else if (i_btn && r_cnt == LONG_LAST) begin
          w_next         = S_LONG_HELD;
          w_cnt_nxt      = '0;
          w_evt[EV_LONG] = 1'b1;
        end else if (i_btn) begin
          w_cnt_nxt = w_inc;
        end
      end
      S_WAIT_GAP: begin
        if (w_rise) begin
          w_next           = S_SECOND;
          w_cnt_nxt        = '0;
          w_evt[EV_DOUBLE] = 1'b1;
        end else if (r_cnt == GAP_LAST) begin
          w_next          = S_IDLE;
          w_cnt_nxt       = '0;
          w_evt[EV_SHORT] = 1'b1;
        end else begin
          w_cnt_nxt = w_inc;
        end
      end
      S_SECOND: begin
        if (w_fall) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end
      end
      S_LONG_HELD: begin
        if (w_fall) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (r_cnt == REP_LAST) begin
          w_rep     = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = w_inc;
        end
`endif
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_evt   <= '0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_evt   <= w_evt;
      r_held  <= (w_next == S_LONG_HELD);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rep <= 1'b0;
    else          r_rep <= w_rep;
  end
  assign o_repeat = r_rep;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_short  = r_evt[EV_SHORT];
  assign o_long   = r_evt[EV_LONG];
  assign o_double = r_evt[EV_DOUBLE];
  assign o_held   = r_held;

endmodule
